// File: rtl/enemy_ball_hp_if.sv
// Pixel-side bundle between the VGA timing/mixer fabric and one enemy sprite.
// The master drives the raster position and occupancy; the sprite answers with draw_ene.
interface enemy_ball_hp_if;
  logic       pixpulse;
  logic [9:0] hcount;
  logic [9:0] vcount;
  logic [2:0] empty;
  logic       move;
  logic       draw_ene;

  modport master (output pixpulse, hcount, vcount, empty, move, input draw_ene);
  modport slave  (input pixpulse, hcount, vcount, empty, move, output draw_ene);
endinterface

// File: rtl/enemy_ball_hp.sv
// Bouncing enemy sprite with hit points, a blinking invulnerability window after
// damage and an optional timed respawn, scanned against the VGA raster.
module enemy_ball_hp #(
  parameter int XSIZE          = 21,
  parameter int YSIZE          = 21,
  parameter int SPEED          = 1,
  parameter int HP_MAX         = 3,
  parameter int INVULN_FRAMES  = 32,
  parameter int RESPAWN_FRAMES = 120
) (
  input  logic           clk,
  input  logic           rst,
  enemy_ball_hp_if.slave vga,
  input  logic [9:0]     xloc_start,
  input  logic [9:0]     yloc_start,
  input  logic           xdir_start,
  input  logic           ydir_start,
  output logic [9:0]     xloc,
  output logic [9:0]     yloc,
  output logic [3:0]     hp,
  output logic           alive,
  output logic           killed
);

  typedef enum logic [1:0] {ALIVE, HURT, DEAD} state_t;

  localparam logic [9:0] HX      = 10'((XSIZE - 1) / 2);
  localparam logic [9:0] HY      = 10'((YSIZE - 1) / 2);
  localparam logic [9:0] XW      = 10'(XSIZE + 1);
  localparam logic [9:0] YW      = 10'(YSIZE + 1);
  localparam logic [9:0] STEP    = 10'(SPEED);
  localparam logic [3:0] HP_INIT = 4'(HP_MAX);
  localparam logic [7:0] INV_CNT = 8'(INVULN_FRAMES);
  localparam logic [7:0] RSP_CNT = 8'(RESPAWN_FRAMES);

  state_t           state;
  logic             xdir, ydir;
  logic [7:0]       cnt;
  logic [YSIZE+1:0] occ_lft, occ_rgt;
  logic [XSIZE+1:0] occ_top, occ_bot;
  logic             dmg, move_d;

  // Raster position relative to the ring origin, one pixel up-left of the box.
  logic [9:0] rx, ry;
  logic       in_box, on_ring;
  assign rx      = vga.hcount - (xloc - HX - 10'd1);
  assign ry      = vga.vcount - (yloc - HY - 10'd1);
  assign in_box  = (rx >= 10'd1) && (rx <= 10'(XSIZE)) && (ry >= 10'd1) && (ry <= 10'(YSIZE));
  assign on_ring = (rx <= XW) && (ry <= YW) && !in_box;

  logic [YSIZE+1:0] hit_lft, hit_rgt;
  logic [XSIZE+1:0] hit_top, hit_bot;
  always_comb begin
    hit_lft = '0;
    hit_rgt = '0;
    hit_top = '0;
    hit_bot = '0;
    for (int i = 0; i < YSIZE + 2; i++) begin
      hit_lft[i] = on_ring && (rx == 10'd0) && (ry == 10'(i));
      hit_rgt[i] = on_ring && (rx == XW)    && (ry == 10'(i));
    end
    for (int i = 0; i < XSIZE + 2; i++) begin
      hit_top[i] = on_ring && (ry == 10'd0) && (rx == 10'(i));
      hit_bot[i] = on_ring && (ry == YW)    && (rx == 10'(i));
    end
  end

  // A side bounce takes priority; the diagonal corner only matters when both leading sides are clear.
  logic side_x, side_y, corner, flip_x, flip_y, nxdir, nydir;
  logic [9:0] nx, ny;
  always_comb begin
    side_x = xdir ? |occ_rgt[YSIZE:1] : |occ_lft[YSIZE:1];
    side_y = ydir ? |occ_bot[XSIZE:1] : |occ_top[XSIZE:1];
    if (xdir)
      corner = ydir ? (occ_rgt[YSIZE+1] | occ_bot[XSIZE+1]) : (occ_rgt[0] | occ_top[XSIZE+1]);
    else
      corner = ydir ? (occ_lft[YSIZE+1] | occ_bot[0]) : (occ_lft[0] | occ_top[0]);
    flip_x = side_x | (!side_x && !side_y && corner);
    flip_y = side_y | (!side_x && !side_y && corner);
    nxdir  = xdir ^ flip_x;
    nydir  = ydir ^ flip_y;
    nx     = nxdir ? xloc + STEP : xloc - STEP;
    ny     = nydir ? yloc + STEP : yloc - STEP;
  end

  assign vga.draw_ene = in_box && ((state == ALIVE) || ((state == HURT) && !cnt[2]));

  always_ff @(posedge clk) begin
    if (rst) begin
      xloc    <= xloc_start;
      yloc    <= yloc_start;
      xdir    <= xdir_start;
      ydir    <= ydir_start;
      hp      <= HP_INIT;
      state   <= ALIVE;
      cnt     <= '0;
      occ_lft <= '0;
      occ_rgt <= '0;
      occ_top <= '0;
      occ_bot <= '0;
      dmg     <= 1'b0;
      move_d  <= 1'b0;
      killed  <= 1'b0;
      alive   <= 1'b1;
    end else begin
      killed <= 1'b0;
      move_d <= vga.pixpulse && vga.move;
      if (move_d) begin
        occ_lft <= '0;
        occ_rgt <= '0;
        occ_top <= '0;
        occ_bot <= '0;
        dmg     <= 1'b0;
      end else if (vga.pixpulse && !vga.move && (state != DEAD) && (vga.empty != 3'b111)) begin
        occ_lft <= occ_lft | hit_lft;
        occ_rgt <= occ_rgt | hit_rgt;
        occ_top <= occ_top | hit_top;
        occ_bot <= occ_bot | hit_bot;
        if ((state == ALIVE) && !vga.empty[0] && on_ring)
          dmg <= 1'b1;
      end
      if (vga.pixpulse && vga.move) begin
        case (state)
          ALIVE: begin
            xloc <= nx;
            yloc <= ny;
            xdir <= nxdir;
            ydir <= nydir;
            if (dmg) begin
              if (hp > 4'd1) begin
                hp    <= hp - 4'd1;
                cnt   <= INV_CNT;
                state <= HURT;
              end else begin
                hp     <= '0;
                killed <= 1'b1;
                cnt    <= RSP_CNT;
                state  <= DEAD;
                alive  <= 1'b0;
              end
            end
          end
          HURT: begin
            xloc <= nx;
            yloc <= ny;
            xdir <= nxdir;
            ydir <= nydir;
            cnt  <= cnt - 8'd1;
            if (cnt == 8'd1)
              state <= ALIVE;
          end
          DEAD: begin
            // A zero respawn time parks the sprite here until reset.
            if (RSP_CNT != 8'd0) begin
              cnt <= cnt - 8'd1;
              if (cnt == 8'd1) begin
                xloc  <= xloc_start;
                yloc  <= yloc_start;
                xdir  <= xdir_start;
                ydir  <= ydir_start;
                hp    <= HP_INIT;
                state <= ALIVE;
                alive <= 1'b1;
              end
            end
          end
          default: state <= ALIVE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_enemy_ball_hp.sv
// Directed bench for enemy_ball_hp: motion, bounces, damage/blink, death, respawn and reset.
// Two instances share stimulus: one respawns after 4 moves, the other never respawns.
module tb_enemy_ball_hp;
  logic       clk = 1'b0;
  logic       rst;
  logic       pixpulse, move;
  logic [9:0] hcount, vcount;
  logic [2:0] empty;
  logic [9:0] xs, ys;
  logic       xds, yds;

  logic [9:0] xloc0, yloc0, xloc1, yloc1;
  logic [3:0] hp0, hp1;
  logic       alive0, alive1, killed0, killed1;

  int compared   = 0;
  int mismatched = 0;
  int kill_cnt0  = 0;

  enemy_ball_hp_if vif0 ();
  enemy_ball_hp_if vif1 ();

  assign vif0.pixpulse = pixpulse;
  assign vif0.hcount   = hcount;
  assign vif0.vcount   = vcount;
  assign vif0.empty    = empty;
  assign vif0.move     = move;
  assign vif1.pixpulse = pixpulse;
  assign vif1.hcount   = hcount;
  assign vif1.vcount   = vcount;
  assign vif1.empty    = empty;
  assign vif1.move     = move;

  enemy_ball_hp #(.RESPAWN_FRAMES(4)) dut0 (
    .clk(clk), .rst(rst), .vga(vif0),
    .xloc_start(xs), .yloc_start(ys), .xdir_start(xds), .ydir_start(yds),
    .xloc(xloc0), .yloc(yloc0), .hp(hp0), .alive(alive0), .killed(killed0)
  );

  enemy_ball_hp #(.RESPAWN_FRAMES(0)) dut1 (
    .clk(clk), .rst(rst), .vga(vif1),
    .xloc_start(xs), .yloc_start(ys), .xdir_start(xds), .ydir_start(yds),
    .xloc(xloc1), .yloc(yloc1), .hp(hp1), .alive(alive1), .killed(killed1)
  );

  always #5 clk = ~clk;

  // Counts clocks with killed high, so a stretched pulse shows up as a count above one.
  always @(negedge clk) if (killed0 === 1'b1) kill_cnt0++;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: time limit reached before the end of the sequence");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // One pixpulse slot (4 clocks) carrying the given pixel, occupancy and move strobe.
  task automatic applyStimulus(input logic [9:0] h, input logic [9:0] v,
                               input logic [2:0] e, input logic mv);
    @(negedge clk);
    hcount = h; vcount = v; empty = e; move = mv; pixpulse = 1'b1;
    @(negedge clk);
    pixpulse = 1'b0; move = 1'b0; empty = 3'b111;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic doMoves(input int n);
    for (int i = 0; i < n; i++) applyStimulus(10'd0, 10'd0, 3'b111, 1'b1);
  endtask

  task automatic hitThenMove(input logic [9:0] h, input logic [9:0] v, input logic [2:0] e);
    applyStimulus(h, v, e, 1'b0);
    doMoves(1);
  endtask

  task automatic probe(input logic [9:0] h, input logic [9:0] v);
    @(negedge clk);
    hcount = h; vcount = v; pixpulse = 1'b0; move = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1; pixpulse = 1'b0; move = 1'b0; empty = 3'b111;
    hcount = '0; vcount = '0;
    xs = 10'd100; ys = 10'd100; xds = 1'b1; yds = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_xloc", 32'(xloc0), 32'd100);
    checkOutput("rst_yloc", 32'(yloc0), 32'd100);
    checkOutput("rst_hp", 32'(hp0), 32'd3);
    checkOutput("rst_alive", 32'(alive0), 32'd1);
    checkOutput("rst_killed", 32'(killed0), 32'd0);

    // Free motion down-right, then the box edges.
    doMoves(10);
    checkOutput("free_xloc", 32'(xloc0), 32'd110);
    checkOutput("free_yloc", 32'(yloc0), 32'd110);
    checkOutput("free_hp", 32'(hp0), 32'd3);
    probe(10'd110, 10'd110); checkOutput("draw_centre", 32'(vif0.draw_ene), 32'd1);
    probe(10'd120, 10'd120); checkOutput("draw_corner", 32'(vif0.draw_ene), 32'd1);
    probe(10'd121, 10'd110); checkOutput("draw_right_out", 32'(vif0.draw_ene), 32'd0);
    probe(10'd110, 10'd99);  checkOutput("draw_top_out", 32'(vif0.draw_ene), 32'd0);

    // Right-side wall reverses x only.
    hitThenMove(10'd121, 10'd110, 3'b101);
    checkOutput("wall_xloc", 32'(xloc0), 32'd109);
    checkOutput("wall_yloc", 32'(yloc0), 32'd111);
    doMoves(1);
    checkOutput("wall_after_xloc", 32'(xloc0), 32'd108);
    checkOutput("wall_after_yloc", 32'(yloc0), 32'd112);

    // Leading corner (bottom-left while heading L/D) reverses both axes.
    hitThenMove(10'd97, 10'd123, 3'b101);
    checkOutput("lead_corner_xloc", 32'(xloc0), 32'd109);
    checkOutput("lead_corner_yloc", 32'(yloc0), 32'd111);
    // Trailing corner (bottom-left while heading R/U) is ignored.
    hitThenMove(10'd98, 10'd122, 3'b101);
    checkOutput("trail_corner_xloc", 32'(xloc0), 32'd110);
    checkOutput("trail_corner_yloc", 32'(yloc0), 32'd110);

    // Ring pixel presented on the move slot itself is not recorded.
    applyStimulus(10'd121, 10'd110, 3'b101, 1'b1);
    doMoves(1);
    checkOutput("move_wins_xloc", 32'(xloc0), 32'd112);
    checkOutput("move_wins_yloc", 32'(yloc0), 32'd108);

    // Damage on the leading top side: hp drops and y bounces on the same move.
    hitThenMove(10'd112, 10'd97, 3'b110);
    checkOutput("hurt_hp", 32'(hp0), 32'd2);
    checkOutput("hurt_xloc", 32'(xloc0), 32'd113);
    checkOutput("hurt_yloc", 32'(yloc0), 32'd109);
    checkOutput("hurt_alive", 32'(alive0), 32'd1);
    probe(10'd113, 10'd109); checkOutput("blink_cnt32", 32'(vif0.draw_ene), 32'd1);
    doMoves(1);
    probe(10'd114, 10'd110); checkOutput("blink_cnt31", 32'(vif0.draw_ene), 32'd0);
    doMoves(3);
    probe(10'd117, 10'd113); checkOutput("blink_cnt28", 32'(vif0.draw_ene), 32'd0);
    doMoves(1);
    probe(10'd118, 10'd114); checkOutput("blink_cnt27", 32'(vif0.draw_ene), 32'd1);
    hitThenMove(10'd118, 10'd103, 3'b110);
    checkOutput("hurt_ignore_hp", 32'(hp0), 32'd2);
    doMoves(25);
    // Hit on the 32nd move still lands in HURT; the next one lands in ALIVE.
    hitThenMove(10'd144, 10'd129, 3'b110);
    checkOutput("hurt_last_hp", 32'(hp0), 32'd2);
    checkOutput("hurt_last_xloc", 32'(xloc0), 32'd145);
    hitThenMove(10'd145, 10'd130, 3'b110);
    checkOutput("second_hit_hp", 32'(hp0), 32'd1);
    doMoves(32);
    checkOutput("pre_fatal_xloc", 32'(xloc0), 32'd178);
    checkOutput("pre_fatal_hp", 32'(hp0), 32'd1);

    // Fatal hit on both instances.
    hitThenMove(10'd178, 10'd163, 3'b110);
    checkOutput("dead_hp", 32'(hp0), 32'd0);
    checkOutput("dead_alive", 32'(alive0), 32'd0);
    checkOutput("killed_pulses", 32'(kill_cnt0), 32'd1);
    checkOutput("dead_xloc", 32'(xloc0), 32'd179);
    checkOutput("dead_yloc", 32'(yloc0), 32'd175);
    probe(10'd179, 10'd175); checkOutput("dead_draw", 32'(vif0.draw_ene), 32'd0);
    checkOutput("norsp_alive", 32'(alive1), 32'd0);
    checkOutput("norsp_hp", 32'(hp1), 32'd0);

    doMoves(3);
    checkOutput("dead_wait_alive", 32'(alive0), 32'd0);
    checkOutput("dead_frozen_xloc", 32'(xloc0), 32'd179);
    doMoves(1);
    checkOutput("respawn_alive", 32'(alive0), 32'd1);
    checkOutput("respawn_xloc", 32'(xloc0), 32'd100);
    checkOutput("respawn_yloc", 32'(yloc0), 32'd100);
    checkOutput("respawn_hp", 32'(hp0), 32'd3);
    checkOutput("killed_pulses_after", 32'(kill_cnt0), 32'd1);
    probe(10'd100, 10'd100); checkOutput("respawn_draw", 32'(vif0.draw_ene), 32'd1);

    doMoves(1000);
    checkOutput("norsp_1000_alive", 32'(alive1), 32'd0);
    checkOutput("norsp_1000_xloc", 32'(xloc1), 32'd179);
    checkOutput("norsp_1000_hp", 32'(hp1), 32'd0);
    probe(10'd179, 10'd175); checkOutput("norsp_draw", 32'(vif1.draw_ene), 32'd0);

    // Reset mid-HURT with cnt at 10, coinciding with a move slot.
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    hitThenMove(10'd100, 10'd89, 3'b110);
    doMoves(22);
    checkOutput("pre_rst_hp", 32'(hp0), 32'd2);
    checkOutput("pre_rst_xloc", 32'(xloc0), 32'd123);
    @(negedge clk);
    rst = 1'b1; pixpulse = 1'b1; move = 1'b1;
    @(negedge clk);
    rst = 1'b0; pixpulse = 1'b0; move = 1'b0;
    checkOutput("rst_hurt_xloc", 32'(xloc0), 32'd100);
    checkOutput("rst_hurt_yloc", 32'(yloc0), 32'd100);
    checkOutput("rst_hurt_hp", 32'(hp0), 32'd3);
    checkOutput("rst_hurt_alive", 32'(alive0), 32'd1);
    doMoves(1);
    checkOutput("post_rst_xloc", 32'(xloc0), 32'd101);
    checkOutput("post_rst_yloc", 32'(yloc0), 32'd101);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
